// File: rtl/nios_mem_pkg.sv
// Shared types and constants for the dual-port Nios on-chip memory.
package nios_mem_pkg;

    // Power-up sequencing: hold one cycle, optionally sweep zeros, then serve traffic
    typedef enum logic [1:0] {
        RESET_HOLD,
        CLEAR,
        READY
    } mem_state_e;

    // Deepest read pipeline supported (RAM register plus one output register)
    localparam int MAX_READ_LATENCY = 2;

    // Number of byte lanes for a given data width
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/nios_system_dpram_core.sv
// True dual-port byte-enable RAM with registered read data (latency 1).
// A read and a write to the same word in one cycle returns the old word.
module nios_system_dpram_core
    import nios_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 15,
    parameter string INIT_FILE = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_i,
    input  logic [ADDR_W-1:0]           a_address_i,
    input  logic                        a_we_i,
    input  logic [be_width(DATA_W)-1:0] a_byteenable_i,
    input  logic [DATA_W-1:0]           a_writedata_i,
    output logic [DATA_W-1:0]           a_readdata_o,
    input  logic [ADDR_W-1:0]           b_address_i,
    input  logic                        b_we_i,
    input  logic [be_width(DATA_W)-1:0] b_byteenable_i,
    input  logic [DATA_W-1:0]           b_writedata_i,
    output logic [DATA_W-1:0]           b_readdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = be_width(DATA_W);

    // The vendor flow preloads the array from the image named here
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Byte-lane writes from both ports; the top never lets both write one word together
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (a_we_i && a_byteenable_i[b]) begin
                    mem[a_address_i][b*8 +: 8] <= a_writedata_i[b*8 +: 8];
                end
                if (b_we_i && b_byteenable_i[b]) begin
                    mem[b_address_i][b*8 +: 8] <= b_writedata_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read of the pre-write contents on both ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (en_i) begin
            a_rdata_q <= mem[a_address_i];
            b_rdata_q <= mem[b_address_i];
        end
    end

    assign a_readdata_o = a_rdata_q;
    assign b_readdata_o = b_rdata_q;

endmodule

// File: rtl/nios_system_onchip_mem_dp.sv
// Dual-slave Avalon-MM on-chip memory: power-up sequencing, optional zero sweep,
// same-address write arbitration and a one- or two-stage read pipeline.
module nios_system_onchip_mem_dp
    import nios_mem_pkg::*;
#(
    parameter int    DATA_W         = 32,
    parameter int    ADDR_W         = 15,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = "nios_system_program_memory.hex"
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clken,
    input  logic [ADDR_W-1:0]           s1_address,
    input  logic                        s1_chipselect,
    input  logic                        s1_read,
    input  logic                        s1_write,
    input  logic [be_width(DATA_W)-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]           s1_writedata,
    output logic [DATA_W-1:0]           s1_readdata,
    output logic                        s1_readdatavalid,
    output logic                        s1_waitrequest,
    input  logic [ADDR_W-1:0]           s2_address,
    input  logic                        s2_chipselect,
    input  logic                        s2_read,
    input  logic                        s2_write,
    input  logic [be_width(DATA_W)-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]           s2_writedata,
    output logic [DATA_W-1:0]           s2_readdata,
    output logic                        s2_readdatavalid,
    output logic                        s2_waitrequest,
    output logic                        init_done
);

    localparam int BE_W = be_width(DATA_W);
    localparam int LAT  = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                          ((READ_LATENCY < 1) ? 1 : READ_LATENCY);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic [LAT-1:0]    s1_vld_q, s1_vld_d;
    logic [LAT-1:0]    s2_vld_q, s2_vld_d;

    logic              ready;
    logic              s2_collision;
    logic              s1_acc, s2_acc;
    logic              s1_rd_acc, s2_rd_acc;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [BE_W-1:0]   a_be;
    logic [DATA_W-1:0] a_wd;
    logic [DATA_W-1:0] s1_core_rdata, s2_core_rdata;

    assign ready        = (state_q == READY);
    assign s2_collision = s1_chipselect & s1_write & s2_chipselect & s2_write &
                          (s1_address == s2_address);

    assign s1_waitrequest = ~ready | ~clken;
    assign s2_waitrequest = ~ready | ~clken | s2_collision;

    assign s1_acc    = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign s2_acc    = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign s1_rd_acc = s1_acc & s1_read & ~s1_write;
    assign s2_rd_acc = s2_acc & s2_read & ~s2_write;

    // Sequencer registers; reset lands in RESET_HOLD so release is always clean
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_HOLD;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Next state: sweep advances only on enabled cycles and ends after the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RESET_HOLD: state_d = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            CLEAR: begin
                if (clken) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_d = READY;
                    end
                end
            end
            READY:   state_d = READY;
            default: state_d = RESET_HOLD;
        endcase
        init_done_d = (state_d == READY);
    end

    // Port A carries the zero sweep while clearing, otherwise the s1 master
    always_comb begin
        a_addr = s1_address;
        a_we   = s1_acc & s1_write;
        a_be   = s1_byteenable;
        a_wd   = s1_writedata;
        if (state_q == CLEAR) begin
            a_addr = cnt_q;
            a_we   = 1'b1;
            a_be   = '1;
            a_wd   = '0;
        end
    end

    nios_system_dpram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk            (clk),
        .reset          (reset),
        .en_i           (clken),
        .a_address_i    (a_addr),
        .a_we_i         (a_we),
        .a_byteenable_i (a_be),
        .a_writedata_i  (a_wd),
        .a_readdata_o   (s1_core_rdata),
        .b_address_i    (s2_address),
        .b_we_i         (s2_acc & s2_write),
        .b_byteenable_i (s2_byteenable),
        .b_writedata_i  (s2_writedata),
        .b_readdata_o   (s2_core_rdata)
    );

    // Read-valid shift: a new accept enters stage 0, older ones move one stage on
    always_comb begin
        s1_vld_d    = s1_vld_q;
        s2_vld_d    = s2_vld_q;
        s1_vld_d[0] = s1_rd_acc;
        s2_vld_d[0] = s2_rd_acc;
        for (int i = 1; i < LAT; i++) begin
            s1_vld_d[i] = s1_vld_q[i-1];
            s2_vld_d[i] = s2_vld_q[i-1];
        end
    end

    // Valid pipeline freezes with clken so a pending strobe is held, not dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= '0;
            s2_vld_q <= '0;
        end else if (clken) begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    generate
        if (LAT == 2) begin : g_out_reg
            logic [DATA_W-1:0] s1_rdata_q, s2_rdata_q;

            // Extra output stage tracking the RAM read register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_rdata_q <= '0;
                    s2_rdata_q <= '0;
                end else if (clken) begin
                    s1_rdata_q <= s1_core_rdata;
                    s2_rdata_q <= s2_core_rdata;
                end
            end

            assign s1_readdata = s1_rdata_q;
            assign s2_readdata = s2_rdata_q;
        end else begin : g_no_out_reg
            assign s1_readdata = s1_core_rdata;
            assign s2_readdata = s2_core_rdata;
        end
    endgenerate

    assign s1_readdatavalid = s1_vld_q[LAT-1] & clken;
    assign s2_readdatavalid = s2_vld_q[LAT-1] & clken;
    assign init_done        = init_done_q;

endmodule

// File: tb/tb_nios_system_onchip_mem_dp.sv
// Directed bench for the dual-port memory: 16 words, two-cycle reads, zero sweep.
module tb_nios_system_onchip_mem_dp;

    logic        clk;
    logic        reset;
    logic        clken;
    logic [3:0]  s1_address, s2_address;
    logic        s1_chipselect, s2_chipselect;
    logic        s1_read, s2_read;
    logic        s1_write, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic        s1_waitrequest, s2_waitrequest;
    logic        init_done;

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [31:0] rdData;
    logic [31:0] rdData2;
    int          rdLat;
    logic [7:0]  vldPattern;
    logic [31:0] seenData [4];
    int          nSeen;

    nios_system_onchip_mem_dp #(
        .DATA_W         (32),
        .ADDR_W         (4),
        .READ_LATENCY   (2),
        .CLEAR_ON_RESET (1),
        .INIT_FILE      ("")
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clken            (clken),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_waitrequest   (s1_waitrequest),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .s2_waitrequest   (s2_waitrequest),
        .init_done        (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic rd, input logic wr, input logic [3:0] addr,
                                 input logic [3:0] be, input logic [31:0] wd);
        if (port == 1) begin
            s1_chipselect = rd | wr;
            s1_read       = rd;
            s1_write      = wr;
            s1_address    = addr;
            s1_byteenable = be;
            s1_writedata  = wd;
        end else begin
            s2_chipselect = rd | wr;
            s2_read       = rd;
            s2_write      = wr;
            s2_address    = addr;
            s2_byteenable = be;
            s2_writedata  = wd;
        end
    endtask

    task automatic applyIdle();
        s1_chipselect = 1'b0;
        s1_read       = 1'b0;
        s1_write      = 1'b0;
        s2_chipselect = 1'b0;
        s2_read       = 1'b0;
        s2_write      = 1'b0;
    endtask

    task automatic writeWord(input int port, input logic [3:0] addr, input logic [3:0] be, input logic [31:0] wd);
        applyStimulus(port, 1'b0, 1'b1, addr, be, wd);
        tick();
        applyIdle();
    endtask

    task automatic waitValid(input int port, output logic [31:0] data, output int lat);
        lat  = 0;
        data = '0;
        for (int n = 1; n <= 8; n++) begin
            #1;
            if ((port == 1) ? s1_readdatavalid : s2_readdatavalid) begin
                data = (port == 1) ? s1_readdata : s2_readdata;
                lat  = n;
                break;
            end
            tick();
        end
    endtask

    task automatic readWord(input int port, input logic [3:0] addr, output logic [31:0] data, output int lat);
        applyStimulus(port, 1'b1, 1'b0, addr, 4'h0, 32'h0);
        tick();
        applyIdle();
        waitValid(port, data, lat);
    endtask

    task automatic waitInit(input string tag);
        int initCycle;
        int hiCycles;
        initCycle = -1;
        hiCycles  = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (init_done) begin
                initCycle = c;
                break;
            end
            if (s1_waitrequest && s2_waitrequest) hiCycles++;
            tick();
        end
        checkOutput({tag, "_init_cycle"}, initCycle, 17);
        checkOutput({tag, "_wait_cycles"}, hiCycles, 17);
        checkOutput({tag, "_s1_wait_ready"}, s1_waitrequest, 0);
        checkOutput({tag, "_s2_wait_ready"}, s2_waitrequest, 0);
    endtask

    task automatic freezeCheck(input int holdOff, input string tag);
        int seen;
        int frozenValids;
        logic [31:0] got;
        seen         = 0;
        frozenValids = 0;
        got          = '0;
        applyStimulus(1, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0);
        tick();
        applyIdle();
        for (int c = 1; c <= 12; c++) begin
            clken = (c >= 1 + holdOff && c < 4 + holdOff) ? 1'b0 : 1'b1;
            #1;
            if (s1_readdatavalid) begin
                seen++;
                got = s1_readdata;
                if (!clken) frozenValids++;
            end
            tick();
        end
        clken = 1'b1;
        checkOutput({tag, "_valid_count"}, seen, 1);
        checkOutput({tag, "_frozen_valids"}, frozenValids, 0);
        checkOutput({tag, "_data"}, got, 32'h0000_0022);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_s1_rdata"}, s1_readdata, 32'h0);
        checkOutput({tag, "_s2_rdata"}, s2_readdata, 32'h0);
        checkOutput({tag, "_s1_rdv"}, s1_readdatavalid, 0);
        checkOutput({tag, "_s2_rdv"}, s2_readdatavalid, 0);
        checkOutput({tag, "_s1_wait"}, s1_waitrequest, 1);
        checkOutput({tag, "_s2_wait"}, s2_waitrequest, 1);
        checkOutput({tag, "_init_done"}, init_done, 0);
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        applyStimulus(2, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        tick();
        tick();
        tick();
        #1;
        checkResetOutputs("por");

        // Power-up sweep: 1 hold + 16 clear cycles, then every word reads zero
        reset = 1'b0;
        waitInit("sweep");
        for (int a = 0; a < 16; a++) begin
            readWord(1, 4'(a), rdData, rdLat);
            checkOutput($sformatf("clear_rd_%0d", a), rdData, 32'h0);
        end

        // Write then read back with two-cycle latency
        writeWord(1, 4'd5, 4'hF, 32'hDEAD_BEEF);
        readWord(1, 4'd5, rdData, rdLat);
        checkOutput("lat2_data", rdData, 32'hDEAD_BEEF);
        checkOutput("lat2_latency", rdLat, 2);

        // Four back-to-back reads give four consecutive valids in order
        for (int i = 0; i < 4; i++) writeWord(1, 4'(10 + i), 4'hF, 32'hC0DE_0000 + 32'(i));
        nSeen      = 0;
        vldPattern = '0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) applyStimulus(1, 1'b1, 1'b0, 4'(10 + c), 4'h0, 32'h0);
            else applyIdle();
            #1;
            vldPattern[c] = s1_readdatavalid;
            if (s1_readdatavalid && nSeen < 4) begin
                seenData[nSeen] = s1_readdata;
                nSeen++;
            end
            tick();
        end
        checkOutput("b2b_valid_pattern", vldPattern, 8'b0011_1100);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b_data_%0d", i), seenData[i], 32'hC0DE_0000 + 32'(i));
        end

        // Byte-lane merges on both ports
        writeWord(1, 4'd3, 4'hF, 32'hFFFF_FFFF);
        writeWord(1, 4'd3, 4'b0101, 32'h1234_5678);
        readWord(1, 4'd3, rdData, rdLat);
        checkOutput("be_s1_merge", rdData, 32'hFF34_FF78);
        writeWord(2, 4'd4, 4'hF, 32'hFFFF_FFFF);
        writeWord(2, 4'd4, 4'b1010, 32'h1234_5678);
        readWord(2, 4'd4, rdData, rdLat);
        checkOutput("be_s2_merge", rdData, 32'h12FF_56FF);

        // Same-address write collision: s1 goes first, held s2 lands next cycle
        applyStimulus(1, 1'b0, 1'b1, 4'd7, 4'hF, 32'hAAAA_0000);
        applyStimulus(2, 1'b0, 1'b1, 4'd7, 4'hF, 32'h0000_BBBB);
        #1;
        checkOutput("coll_s2_wait", s2_waitrequest, 1);
        checkOutput("coll_s1_wait", s1_waitrequest, 0);
        tick();
        applyIdle();
        applyStimulus(2, 1'b0, 1'b1, 4'd7, 4'hF, 32'h0000_BBBB);
        #1;
        checkOutput("coll_s2_retry_wait", s2_waitrequest, 0);
        tick();
        applyIdle();
        readWord(1, 4'd7, rdData, rdLat);
        checkOutput("coll_s1_final", rdData, 32'h0000_BBBB);
        readWord(2, 4'd7, rdData, rdLat);
        checkOutput("coll_s2_final", rdData, 32'h0000_BBBB);

        // Read/write overlap on one word returns the old contents, no stall
        writeWord(1, 4'd9, 4'hF, 32'h0000_0011);
        writeWord(1, 4'd8, 4'hF, 32'h0000_0033);
        applyStimulus(1, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0);
        applyStimulus(2, 1'b0, 1'b1, 4'd9, 4'hF, 32'h0000_0022);
        #1;
        checkOutput("rw_s2_wait", s2_waitrequest, 0);
        tick();
        applyIdle();
        waitValid(1, rdData, rdLat);
        checkOutput("rw_s1_old", rdData, 32'h0000_0011);
        readWord(1, 4'd9, rdData, rdLat);
        checkOutput("rw_s1_new", rdData, 32'h0000_0022);
        applyStimulus(2, 1'b1, 1'b0, 4'd8, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 4'd8, 4'hF, 32'h0000_0044);
        #1;
        checkOutput("wr_s2_wait", s2_waitrequest, 0);
        tick();
        applyIdle();
        waitValid(2, rdData, rdLat);
        checkOutput("wr_s2_old", rdData, 32'h0000_0033);
        readWord(2, 4'd8, rdData, rdLat);
        checkOutput("wr_s2_new", rdData, 32'h0000_0044);

        // Simultaneous reads from both ports are both accepted and return together
        applyStimulus(1, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
        applyStimulus(2, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
        #1;
        checkOutput("dual_rd_s1_wait", s1_waitrequest, 0);
        checkOutput("dual_rd_s2_wait", s2_waitrequest, 0);
        tick();
        applyIdle();
        waitValid(1, rdData, rdLat);
        rdData2 = s2_readdatavalid ? s2_readdata : 32'h0;
        checkOutput("dual_rd_s1_data", rdData, 32'hDEAD_BEEF);
        checkOutput("dual_rd_s2_data", rdData2, 32'hDEAD_BEEF);

        // Clock-enable freeze with the read in stage one, then in the output stage
        freezeCheck(0, "freeze_stage1");
        freezeCheck(1, "freeze_stage2");

        // Reset while serving traffic drives outputs to reset values at once
        tick();
        reset = 1'b1;
        #1;
        checkResetOutputs("rst_ready");
        tick();
        tick();

        // Abort the sweep at cnt=6, then the restarted sweep must cover every word
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        #1;
        checkResetOutputs("rst_clear");
        tick();
        tick();
        reset = 1'b0;
        waitInit("resweep");
        readWord(1, 4'd3, rdData, rdLat);
        checkOutput("resweep_rd_3", rdData, 32'h0);
        readWord(1, 4'd5, rdData, rdLat);
        checkOutput("resweep_rd_5", rdData, 32'h0);
        readWord(1, 4'd7, rdData, rdLat);
        checkOutput("resweep_rd_7", rdData, 32'h0);
        readWord(2, 4'd8, rdData, rdLat);
        checkOutput("resweep_rd_8", rdData, 32'h0);
        readWord(1, 4'd9, rdData, rdLat);
        checkOutput("resweep_rd_9", rdData, 32'h0);
        readWord(2, 4'd13, rdData, rdLat);
        checkOutput("resweep_rd_13", rdData, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
